// File: rtl/uparc_lsu_arbiter.sv
// uparc_lsu_arbiter: shares one bus master port between the fetch and data LSU ports, with alignment check and byte-lane steering.
// Optional macro UPARC_LSU_ARB_RR_EN selects round-robin priority; the default is fixed data-over-fetch priority.
module uparc_lsu_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic [1:0]            f_cmd,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  f_busy,
    output logic                  f_err_align,
    output logic                  f_err_bus,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_cmd,
    input  logic                  d_rnw,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_busy,
    output logic                  d_err_align,
    output logic                  d_err_bus,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be,
    output logic                  bus_rnw,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err
);
    localparam logic [1:0] CMD_IDLE = 2'd0, CMD_BYTE = 2'd1, CMD_HWORD = 2'd2, CMD_WORD = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_GNT_D, S_GNT_F} state_t;

    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
        return sz == CMD_BYTE ? 4'b0001 << a : sz == CMD_HWORD ? 4'b0011 << a : 4'b1111;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wdata_of(input logic [1:0] sz, input logic [DATA_WIDTH-1:0] w);
        return sz == CMD_BYTE ? DATA_WIDTH'({4{w[7:0]}}) : sz == CMD_HWORD ? DATA_WIDTH'({2{w[15:0]}}) : w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rdata_of(input logic [1:0] sz, input logic [1:0] a,
                                                       input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] s;
        s = d >> {a, 3'b000};
        return sz == CMD_BYTE ? DATA_WIDTH'(s[7:0]) : sz == CMD_HWORD ? DATA_WIDTH'(s[15:0]) : s;
    endfunction

    state_t                  state_q, state_d;
    logic                    fp_q, dp_q;
    logic [ADDR_WIDTH-1:0]   fa_q, da_q;
    logic [DATA_WIDTH-1:0]   dw_q;
    logic [1:0]              ds_q;
    logic                    dr_q;
    logic                    bus_req_q, bus_rnw_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [DATA_WIDTH-1:0]   bus_wdata_q;
    logic [3:0]              bus_be_q;
    logic [1:0]              bus_size_q;
    logic [DATA_WIDTH-1:0]   f_rdata_q, d_rdata_q;
    logic                    f_err_bus_q, d_err_bus_q;

    logic                    f_mis, d_mis, f_act, d_act, f_new, d_new, f_req, d_req;
    logic                    done, f_grant, d_grant, prio_d;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [1:0]              sel_size;
    logic                    sel_rnw;

    always_comb begin
        f_mis     = f_cmd != CMD_IDLE && f_addr[1:0] != 2'b00;
        d_mis     = (d_cmd == CMD_HWORD && d_addr[0]) || (d_cmd == CMD_WORD && d_addr[1:0] != 2'b00);
        f_act     = state_q == S_GNT_F;
        d_act     = state_q == S_GNT_D;
        // A command on a port that is already busy is dropped
        f_new     = f_cmd != CMD_IDLE && !f_mis && !fp_q && !f_act;
        d_new     = d_cmd != CMD_IDLE && !d_mis && !dp_q && !d_act;
        f_req     = f_new || fp_q;
        d_req     = d_new || dp_q;
        done      = bus_req_q && (bus_ack || bus_err);
        d_grant   = state_q == S_IDLE && d_req && (!f_req || prio_d);
        f_grant   = state_q == S_IDLE && f_req && !d_grant;
        sel_addr  = d_grant ? (dp_q ? da_q : d_addr) : (fp_q ? fa_q : f_addr);
        sel_wdata = d_grant ? (dp_q ? dw_q : d_wdata) : '0;
        sel_size  = d_grant ? (dp_q ? ds_q : d_cmd) : CMD_WORD;
        sel_rnw   = d_grant ? (dp_q ? dr_q : d_rnw) : 1'b1;
        state_d   = d_grant ? S_GNT_D : f_grant ? S_GNT_F : done ? S_IDLE : state_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            fp_q        <= 1'b0;
            dp_q        <= 1'b0;
            fa_q        <= '0;
            da_q        <= '0;
            dw_q        <= '0;
            ds_q        <= CMD_IDLE;
            dr_q        <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_rnw_q   <= 1'b0;
            bus_size_q  <= CMD_IDLE;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_err_bus_q <= 1'b0;
            d_err_bus_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fp_q        <= f_grant ? 1'b0 : fp_q || f_new;
            dp_q        <= d_grant ? 1'b0 : dp_q || d_new;
            f_err_bus_q <= done && bus_err && f_act;
            d_err_bus_q <= done && bus_err && d_act;
            if (f_new) fa_q <= f_addr;
            if (d_new) begin
                da_q <= d_addr;
                dw_q <= d_wdata;
                ds_q <= d_cmd;
                dr_q <= d_rnw;
            end
            if (f_grant || d_grant) begin
                bus_req_q   <= 1'b1;
                bus_addr_q  <= sel_addr;
                bus_wdata_q <= wdata_of(sel_size, sel_wdata);
                bus_be_q    <= be_of(sel_size, sel_addr[1:0]);
                bus_rnw_q   <= sel_rnw;
                bus_size_q  <= sel_size;
            end else if (done) begin
                bus_req_q <= 1'b0;
            end
            if (done && !bus_err && f_act) f_rdata_q <= rdata_of(bus_size_q, bus_addr_q[1:0], bus_rdata);
            if (done && !bus_err && d_act) d_rdata_q <= rdata_of(bus_size_q, bus_addr_q[1:0], bus_rdata);
        end
    end

`ifdef UPARC_LSU_ARB_RR_EN
    // Remembers the winner of the last contended grant so the other port wins the next contention
    logic last_d_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) last_d_q <= 1'b0;
        else if (state_q == S_IDLE && f_req && d_req) last_d_q <= d_grant;
    end
    assign prio_d = !last_d_q;
`else
    assign prio_d = 1'b1;
`endif

    assign f_busy      = f_new || fp_q || f_act;
    assign d_busy      = d_new || dp_q || d_act;
    assign f_err_align = f_mis;
    assign d_err_align = d_mis;
    assign f_err_bus   = f_err_bus_q;
    assign d_err_bus   = d_err_bus_q;
    assign f_rdata     = f_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign bus_req     = bus_req_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign bus_rnw     = bus_rnw_q;
endmodule

// File: tb/tb_uparc_lsu_arbiter.sv
// tb_uparc_lsu_arbiter: directed vector table, collision/reset sequences and a randomized run against a transaction-level model.
// Command encoding: 0 IDLE, 1 BYTE, 2 HWORD, 3 WORD.
module tb_uparc_lsu_arbiter;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
    logic [1:0]  f_cmd = '0, d_cmd = '0;
    logic        d_rnw = 1'b0, bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] f_rdata, d_rdata, bus_addr, bus_wdata;
    logic        f_busy, f_err_align, f_err_bus, d_busy, d_err_align, d_err_bus, bus_req, bus_rnw;
    logic [3:0]  bus_be;

`ifdef UPARC_LSU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    uparc_lsu_arbiter dut (
        .clk(clk), .nrst(nrst),
        .f_addr(f_addr), .f_cmd(f_cmd), .f_rdata(f_rdata), .f_busy(f_busy),
        .f_err_align(f_err_align), .f_err_bus(f_err_bus),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_cmd(d_cmd), .d_rnw(d_rnw), .d_rdata(d_rdata),
        .d_busy(d_busy), .d_err_align(d_err_align), .d_err_bus(d_err_bus),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rnw(bus_rnw), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        bit          dp;
        logic [1:0]  cmd;
        logic [31:0] addr, wdata;
        bit          rnw;
        logic [31:0] rdata;
        bit          berr, align;
        logic [3:0]  be;
        logic [31:0] bwd, rd;
        bit          chkrd;
    } vec_t;

    function automatic vec_t mk(bit dp, logic [1:0] cmd, logic [31:0] addr, logic [31:0] wdata, bit rnw,
                                logic [31:0] rdata, bit berr, bit align, logic [3:0] be,
                                logic [31:0] bwd, logic [31:0] rd, bit chkrd);
        vec_t v;
        v.dp = dp; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.rnw = rnw; v.rdata = rdata;
        v.berr = berr; v.align = align; v.be = be; v.bwd = bwd; v.rd = rd; v.chkrd = chkrd;
        return v;
    endfunction

    // One command, zero-wait completion, then the port must be idle again
    task automatic run_vec(input vec_t v, input int n);
        string s;
        s = $sformatf("vec%0d", n);
        step;
        if (v.dp) begin
            d_cmd = v.cmd; d_addr = v.addr; d_wdata = v.wdata; d_rnw = v.rnw;
        end else begin
            f_cmd = v.cmd; f_addr = v.addr;
        end
        sample;
        chk({s, "_busy"}, v.dp ? d_busy : f_busy, !v.align);
        chk({s, "_err_align"}, v.dp ? d_err_align : f_err_align, v.align);
        step;
        f_cmd = 0; d_cmd = 0;
        if (!v.align) begin
            bus_ack = !v.berr; bus_err = v.berr; bus_rdata = v.rdata;
        end
        sample;
        chk({s, "_bus_req"}, bus_req, !v.align);
        if (!v.align) begin
            chk({s, "_be"}, bus_be, v.be);
            chk({s, "_wdata"}, bus_wdata, v.bwd);
            chk({s, "_addr"}, bus_addr, v.addr);
            chk({s, "_rnw"}, bus_rnw, v.rnw);
        end
        step;
        bus_ack = 0; bus_err = 0;
        sample;
        chk({s, "_busy_done"}, v.dp ? d_busy : f_busy, 0);
        chk({s, "_req_done"}, bus_req, 0);
        if (!v.align) chk({s, "_err_bus"}, v.dp ? d_err_bus : f_err_bus, v.berr);
        if (v.chkrd) chk({s, "_rdata"}, v.dp ? d_rdata : f_rdata, v.rd);
    endtask

    // Data write to 0x40 and fetch from 0x80 in the same cycle
    task automatic collide(input logic [31:0] rd, input bit d_first, input string s);
        step;
        d_cmd = 3; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; d_rnw = 0;
        f_cmd = 3; f_addr = 32'h80;
        sample;
        chk({s, "_f_busy0"}, f_busy, 1);
        chk({s, "_d_busy0"}, d_busy, 1);
        step;
        f_cmd = 0; d_cmd = 0; bus_ack = 1; bus_rdata = rd;
        sample;
        chk({s, "_req1"}, bus_req, 1);
        chk({s, "_addr1"}, bus_addr, d_first ? 32'h40 : 32'h80);
        chk({s, "_rnw1"}, bus_rnw, !d_first);
        chk({s, "_other_busy1"}, d_first ? f_busy : d_busy, 1);
        step;
        bus_ack = 0;
        sample;
        chk({s, "_gap_req"}, bus_req, 0);
        chk({s, "_first_busy"}, d_first ? d_busy : f_busy, 0);
        chk({s, "_second_busy"}, d_first ? f_busy : d_busy, 1);
        step;
        bus_ack = 1;
        sample;
        chk({s, "_req2"}, bus_req, 1);
        chk({s, "_addr2"}, bus_addr, d_first ? 32'h80 : 32'h40);
        step;
        bus_ack = 0;
        sample;
        chk({s, "_f_busy_end"}, f_busy, 0);
        chk({s, "_d_busy_end"}, d_busy, 0);
        chk({s, "_f_rdata"}, f_rdata, rd);
    endtask

    typedef struct {
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        bit          rnw;
    } txn_t;

    function automatic logic [3:0] m_be(txn_t t);
        int sh;
        sh = int'(t.addr[1:0]);
        return t.size == 1 ? 4'(1 << sh) : t.size == 2 ? 4'(3 << sh) : 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(txn_t t);
        return t.size == 1 ? (t.wdata & 32'hFF) * 32'h01010101 :
               t.size == 2 ? (t.wdata & 32'hFFFF) * 32'h00010001 : t.wdata;
    endfunction

    function automatic logic [31:0] m_rd(txn_t t, logic [31:0] r);
        logic [31:0] s;
        s = r >> (8 * int'(t.addr[1:0]));
        return t.size == 1 ? s & 32'hFF : t.size == 2 ? s & 32'hFFFF : s;
    endfunction

    vec_t vt[13];

    initial begin
        txn_t q_f[$], q_d[$];
        txn_t cur, t;
        int   owner;
        bit   last_d, fb, db, f_ok, d_ok, f_mis, d_mis, m_f_eb, m_d_eb, both, pick_d;
        logic [31:0] m_f_rd, m_d_rd;

        vt[0]  = mk(0, 3, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 4'hF, 0, 32'hDEADBEEF, 1);
        vt[1]  = mk(1, 1, 32'h203, 0, 1, 32'h11223344, 0, 0, 4'h8, 0, 32'h00000011, 1);
        vt[2]  = mk(1, 2, 32'h202, 0, 1, 32'h11223344, 0, 0, 4'hC, 0, 32'h00001122, 1);
        vt[3]  = mk(1, 2, 32'h200, 0, 1, 32'h11223344, 0, 0, 4'h3, 0, 32'h00003344, 1);
        vt[4]  = mk(1, 2, 32'h010, 0, 1, 32'hFFFFFFFF, 1, 0, 4'h3, 0, 32'h00003344, 1);
        vt[5]  = mk(1, 1, 32'h041, 32'h000000A7, 0, 0, 0, 0, 4'h2, 32'hA7A7A7A7, 0, 0);
        vt[6]  = mk(1, 2, 32'h042, 32'h1234BEEF, 0, 0, 0, 0, 4'hC, 32'hBEEFBEEF, 0, 0);
        vt[7]  = mk(1, 3, 32'h040, 32'hA5A5A5A5, 0, 0, 0, 0, 4'hF, 32'hA5A5A5A5, 0, 0);
        vt[8]  = mk(1, 3, 32'h102, 0, 1, 0, 0, 1, 4'h0, 0, 0, 0);
        vt[9]  = mk(1, 2, 32'h011, 0, 1, 0, 0, 1, 4'h0, 0, 0, 0);
        vt[10] = mk(0, 3, 32'h101, 0, 1, 0, 0, 1, 4'h0, 0, 0, 0);
        vt[11] = mk(1, 1, 32'h003, 0, 1, 32'h11223344, 0, 0, 4'h8, 0, 32'h00000011, 1);
        vt[12] = mk(1, 3, 32'h080, 0, 1, 32'hCAFEF00D, 0, 0, 4'hF, 0, 32'hCAFEF00D, 1);

        sample;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_f_busy", f_busy, 0);
        chk("rst_d_busy", d_busy, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        step;
        nrst = 1;

        step;
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        step;
        bus_ack = 0;
        sample;
        chk("stray_ack_req", bus_req, 0);
        chk("stray_ack_d_rdata", d_rdata, 0);
        chk("stray_ack_f_rdata", f_rdata, 0);

        foreach (vt[i]) run_vec(vt[i], i);

        collide(32'h0BADF00D, 1'b1, "coll1");
        collide(32'h600DCAFE, !RR, "coll2");

        step;
        d_cmd = 3; d_addr = 32'h80; d_rnw = 1;
        step;
        d_cmd = 0;
        sample;
        chk("mid_rst_pre_req", bus_req, 1);
        nrst = 0; bus_ack = 1; bus_rdata = 32'h12345678;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_d_busy", d_busy, 0);
        chk("mid_rst_d_rdata", d_rdata, 0);
        chk("mid_rst_f_rdata", f_rdata, 0);
        step;
        nrst = 1; bus_ack = 0;
        sample;
        chk("post_rst_req", bus_req, 0);
        chk("post_rst_d_rdata", d_rdata, 0);
        run_vec(vt[0], 100);

        owner = 0; last_d = 0; m_f_eb = 0; m_d_eb = 0;
        m_f_rd = 32'hDEADBEEF; m_d_rd = 0;
        for (int c = 0; c < 3000; c++) begin
            step;
            f_cmd = 0; d_cmd = 0; bus_ack = 0; bus_err = 0;
            fb = q_f.size() != 0 || owner == 2;
            db = q_d.size() != 0 || owner == 1;
            if (!fb && $urandom_range(0, 2) == 0) begin
                f_cmd = 3;
                f_addr = ($urandom & 32'hFFFC) | ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
            end
            if (!db && $urandom_range(0, 2) == 0) begin
                d_cmd = 2'($urandom_range(1, 3));
                d_addr = $urandom; d_wdata = $urandom; d_rnw = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) != 0)
                    d_addr[1:0] = d_cmd == 3 ? 2'b00 : d_cmd == 2 ? {d_addr[1], 1'b0} : d_addr[1:0];
            end
            if (owner != 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: bus_ack = 1;
                    5: bus_err = 1;
                    default: ;
                endcase
            end else if ($urandom_range(0, 15) == 0) begin
                bus_ack = 1;
            end
            bus_rdata = $urandom;
            f_mis = f_cmd != 0 && f_addr[1:0] != 0;
            d_mis = (d_cmd == 2 && d_addr[0]) || (d_cmd == 3 && d_addr[1:0] != 0);
            f_ok = f_cmd != 0 && !f_mis;
            d_ok = d_cmd != 0 && !d_mis;
            sample;
            chk("r_bus_req", bus_req, owner != 0);
            if (owner != 0) begin
                chk("r_bus_addr", bus_addr, cur.addr);
                chk("r_bus_be", bus_be, m_be(cur));
                chk("r_bus_wdata", bus_wdata, m_wd(cur));
                chk("r_bus_rnw", bus_rnw, cur.rnw);
            end
            chk("r_f_busy", f_busy, fb || f_ok);
            chk("r_d_busy", d_busy, db || d_ok);
            chk("r_f_err_align", f_err_align, f_mis);
            chk("r_d_err_align", d_err_align, d_mis);
            chk("r_f_err_bus", f_err_bus, m_f_eb);
            chk("r_d_err_bus", d_err_bus, m_d_eb);
            chk("r_f_rdata", f_rdata, m_f_rd);
            chk("r_d_rdata", d_rdata, m_d_rd);
            m_f_eb = 0; m_d_eb = 0;
            if (f_ok) begin
                t.addr = f_addr; t.wdata = 0; t.size = 3; t.rnw = 1;
                q_f.push_back(t);
            end
            if (d_ok) begin
                t.addr = d_addr; t.wdata = d_wdata; t.size = d_cmd; t.rnw = d_rnw;
                q_d.push_back(t);
            end
            if (owner != 0 && (bus_ack || bus_err)) begin
                if (bus_err) begin
                    if (owner == 1) m_d_eb = 1; else m_f_eb = 1;
                end else if (owner == 1) begin
                    m_d_rd = m_rd(cur, bus_rdata);
                end else begin
                    m_f_rd = m_rd(cur, bus_rdata);
                end
                owner = 0;
            end else if (owner == 0 && (q_f.size() != 0 || q_d.size() != 0)) begin
                both = q_f.size() != 0 && q_d.size() != 0;
                pick_d = q_d.size() != 0 && (!both || !RR || !last_d);
                if (both) last_d = pick_d;
                if (pick_d) begin
                    cur = q_d.pop_front(); owner = 1;
                end else begin
                    cur = q_f.pop_front(); owner = 2;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
